// File: rtl/pipeline_defs.sv
// Shared constants for the RV32I pipeline stages.
package pipeline_defs;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage.
module alu
  import pipeline_defs::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic [W-1:0] Result,
  output logic         Zero
);

  logic slt;

  assign slt = $signed(A) < $signed(B);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(W-1){1'b0}}, slt};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// RV32I execute stage: ALU, branch resolve, EX/MEM register.
// Operand forwarding enabled by EXECUTE_FORWARDING_EN.
module execute_cycle
  import pipeline_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_res;
  logic              zero;

  logic              reg_write_q, mem_write_q, res_src_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_q, wdata_q, pc4_q;

`ifdef EXECUTE_FORWARDING_EN
  // Code 11 falls back to the register value.
  always_comb begin
    src_a = RD1_E;
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    wdata = RD2_E;
    case (ForwardBE)
      FWD_WB:  wdata = ResultW;
      FWD_MEM: wdata = alu_q;
      default: wdata = RD2_E;
    endcase
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
  assign src_a      = RD1_E;
  assign wdata      = RD2_E;
`endif

  assign src_b = ALUSrcE ? Imm_Ext_E : wdata;

  alu #(.W(DATA_W)) u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_res),
    .Zero       (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      res_src_q   <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pc4_q       <= '0;
    end else begin
      reg_write_q <= RegWriteE;
      mem_write_q <= MemWriteE;
      res_src_q   <= ResultSrcE;
      rd_q        <= RD_E;
      alu_q       <= alu_res;
      wdata_q     <= wdata;
      pc4_q       <= PCPlus4E;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = res_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_q;
  assign WriteDataM = wdata_q;
  assign PCPlus4M   = pc4_q;

endmodule
